accum_bcd_converter: RTL and testbench

- Downstream consumer of the N-bit accumulator sum.
- Converts the registered sum (S) into packed BCD digits plus a sign flag for the board's decimal HEX display path.
- Uses a sequential shift-and-add-3 (double-dabble) engine: one bit per clock, start/busy/done handshake.
- Also captures the accumulator's overflow flag alongside each result.

---
 rtl/accum_bcd_if.sv | 26 ++
 rtl/accum_bcd_converter.sv | 112 +++++++++++
 tb/tb_accum_bcd_converter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/accum_bcd_if.sv
// Request/result bundle between the accumulator side and the BCD converter.
// master drives the conversion request; slave returns status and the published result.
interface accum_bcd_if #(
    parameter int N      = 8,
    parameter int DIGITS = 3
) ();
    logic                  start;
    logic [N-1:0]          value;
    logic                  signed_mode;
    logic                  ovf_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  negative;
    logic                  error;

    modport master (
        output start, value, signed_mode, ovf_in,
        input  busy, done, bcd, negative, error
    );

    modport slave (
        input  start, value, signed_mode, ovf_in,
        output busy, done, bcd, negative, error
    );
endinterface

// File: rtl/accum_bcd_converter.sv
// Sequential double-dabble conversion of the accumulator sum to packed BCD plus sign/overflow flags.
// Latency: start sampled at edge E0, done pulses in the cycle after edge E0+N; issue interval N+2.
// Backpressure: none; start is only accepted in IDLE and dropped while busy or in DONE.
module accum_bcd_converter #(
    parameter int N      = 8,
    parameter int DIGITS = 3
) (
    input  logic          clk,
    input  logic          reset,
    accum_bcd_if.slave    bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    operand;
    logic [BW-1:0]   scratch;
    logic [BW-1:0]   adj;
    logic [BW-1:0]   scratch_nxt;
    logic [N-1:0]    operand_nxt;
    logic            neg_r, err_r;
    logic [BW-1:0]   bcd_r;
    logic            negative_r, error_r;
    logic            busy_c, done_c, last;

    assign last = (cnt == CW'(N - 1));

    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
        scratch_nxt = {adj[BW-2:0], operand[N-1]};
        operand_nxt = {operand[N-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_nxt = SHIFT;
            SHIFT: begin
                busy_c = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            operand    <= '0;
            scratch    <= '0;
            neg_r      <= 1'b0;
            err_r      <= 1'b0;
            bcd_r      <= '0;
            negative_r <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    cnt     <= '0;
                    scratch <= '0;
                    err_r   <= bus.ovf_in;
                    // Magnitude of a negative two's-complement input; 2^(N-1) maps to itself.
                    if (bus.signed_mode && bus.value[N-1]) begin
                        operand <= (~bus.value) + N'(1);
                        neg_r   <= 1'b1;
                    end else begin
                        operand <= bus.value;
                        neg_r   <= 1'b0;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    operand <= operand_nxt;
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        bcd_r      <= scratch_nxt;
                        negative_r <= neg_r;
                        error_r    <= err_r;
                    end
                end
                default: ;
            endcase
        end
    end

    // With 10^DIGITS > 2^N the top digit never reaches 5 before a shift, so nothing is lost.
    top_digit_no_carry: assert property (@(posedge clk) disable iff (reset) !(busy_c && adj[BW-1]));

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.bcd      = bcd_r;
    assign bus.negative = negative_r;
    assign bus.error    = error_r;
endmodule

// File: tb/tb_accum_bcd_converter.sv
// Directed bench for accum_bcd_converter: expected results are queued at start and checked on done.
module tb_accum_bcd_converter;
    localparam int N      = 8;
    localparam int DIGITS = 3;
    localparam int BW     = 4 * DIGITS;

    typedef struct packed {
        logic [BW-1:0] bcd;
        logic          neg;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   last_done_cyc = 0;
    int   prev_done_cyc = 0;
    exp_t q[$];

    accum_bcd_if #(.N(N), .DIGITS(DIGITS)) bus ();

    accum_bcd_converter #(.N(N), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [N-1:0] v, input logic sm, input logic ovf);
        exp_t e;
        int   mag;
        int   div = 1;
        e.neg = sm && v[N-1];
        mag   = e.neg ? ((1 << N) - int'(v)) : int'(v);
        e.bcd = '0;
        for (int d = 0; d < DIGITS; d++) begin
            e.bcd[4*d +: 4] = 4'((mag / div) % 10);
            div = div * 10;
        end
        e.err = ovf;
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (bus.done === 1'b1) begin
            exp_t e;
            done_cnt++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            check("sb_expected_pending", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("sb_bcd", 32'(bus.bcd), 32'(e.bcd));
                check("sb_negative", 32'(bus.negative), 32'(e.neg));
                check("sb_error", 32'(bus.error), 32'(e.err));
            end
        end
    end

    always @(posedge clk) cyc++;

    // Returns at the negedge inside the first cycle after E0 (cycle 1).
    task automatic start_conv(input logic [N-1:0] v, input logic sm, input logic ovf, input bit push);
        @(negedge clk);
        bus.value       = v;
        bus.signed_mode = sm;
        bus.ovf_in      = ovf;
        bus.start       = 1'b1;
        if (push) q.push_back(model(v, sm, ovf));
        @(negedge clk);
        bus.start       = 1'b0;
        bus.value       = ~v;
        bus.signed_mode = ~sm;
        bus.ovf_in      = ~ovf;
    endtask

    // lat0 is the current cycle number relative to E0; returns at the negedge of the done cycle.
    task automatic run_to_done(input string tag, input int lat0);
        int            lat = lat0;
        int            bz = 0;
        bit            stable = 1;
        logic [BW-1:0] held = bus.bcd;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) bz++;
            if (bus.bcd !== held) stable = 0;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(N + 1));
        check({tag, "_busy_cycles"}, 32'(bz), 32'(N + 1 - lat0));
        check({tag, "_bcd_held"}, 32'(stable), 32'd1);
        check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int d0;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.value       = '0;
        bus.signed_mode = 1'b0;
        bus.ovf_in      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bcd", 32'(bus.bcd), 32'd0);
        check("rst_negative", 32'(bus.negative), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        start_conv(8'd255, 1'b0, 1'b0, 1);
        check("u255_busy_c1", 32'(bus.busy), 32'd1);
        run_to_done("u255", 1);
        check("u255_bcd", 32'(bus.bcd), 32'h255);

        start_conv(8'h80, 1'b1, 1'b1, 1);
        run_to_done("s80", 1);
        check("s80_bcd", 32'(bus.bcd), 32'h128);
        check("s80_neg", 32'(bus.negative), 32'd1);
        start_conv(8'hFF, 1'b1, 1'b0, 1);
        run_to_done("sFF", 1);
        check("sFF_bcd", 32'(bus.bcd), 32'h001);

        start_conv(8'd0, 1'b0, 1'b0, 1);
        run_to_done("u0", 1);
        start_conv(8'd0, 1'b1, 1'b0, 1);
        run_to_done("s0", 1);
        check("s0_neg", 32'(bus.negative), 32'd0);
        start_conv(8'h80, 1'b0, 1'b0, 1);
        run_to_done("u80", 1);
        check("u80_bcd", 32'(bus.bcd), 32'h128);

        // Restart attempts during SHIFT and during DONE must both be dropped.
        d0 = done_cnt;
        start_conv(8'd99, 1'b0, 1'b0, 1);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        run_to_done("u99", 4);
        bus.start = 1'b1;
        bus.value = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (N + 4) @(negedge clk);
        check("u99_single_done", 32'(done_cnt - d0), 32'd1);
        check("u99_bcd_kept", 32'(bus.bcd), 32'h099);

        // Reset mid-conversion aborts without a done pulse.
        d0 = done_cnt;
        start_conv(8'd200, 1'b0, 1'b1, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_bcd", 32'(bus.bcd), 32'd0);
        check("abort_error", 32'(bus.error), 32'd0);
        repeat (N + 4) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        start_conv(8'd42, 1'b0, 1'b0, 1);
        run_to_done("u42", 1);
        check("u42_bcd", 32'(bus.bcd), 32'h042);

        // Back-to-back issue at the minimum interval.
        start_conv(8'd10, 1'b0, 1'b0, 1);
        run_to_done("u10", 1);
        check("u10_bcd", 32'(bus.bcd), 32'h010);
        start_conv(8'd250, 1'b0, 1'b0, 1);
        run_to_done("u250", 1);
        check("b2b_interval", 32'(last_done_cyc - prev_done_cyc), 32'(N + 2));
        check("u250_bcd", 32'(bus.bcd), 32'h250);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
